sdram_rw_ctrl: RTL and testbench

- Downstream stage of the SDRAM initialization FSM; takes over the SDRAM pins once initialization reports done.
- Serves single-word write and read requests from a user-side handshake: ACTIVATE, then READ/WRITE, then PRECHARGE ALL.
- Issues periodic AUTO REFRESH.
- Relies on the mode register loaded at init: CAS latency 2, burst length 8 read, single-location write.

---
 rtl/sdram_rw_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_sdram_rw_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rw_ctrl.sv
// SDRAM read/write/refresh engine: takes over the SDRAM pins after the init
// stage, serving single-word accesses (ACT, RD/WR, PALL) and periodic refresh.
module sdram_rw_ctrl #(
  parameter int REFRESH_INTERVAL = 390,
  parameter int T_RCD            = 2,
  parameter int T_RP             = 2,
  parameter int T_RC             = 4,
  parameter int T_WR             = 2,
  parameter int CAS_LAT          = 2
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        iinit_done,
  input  logic        ireq_wr,
  input  logic        ireq_rd,
  input  logic [24:0] iaddr,
  input  logic [15:0] iwdata,
  output logic        oack,
  output logic [15:0] ordata,
  output logic        ordata_valid,
  output logic        obusy,
  output logic        DRAM_CLK,
  output logic        DRAM_CKE,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  output logic        DRAM_UDQM,
  output logic        DRAM_LDQM,
  inout  wire  [15:0] DRAM_DQ
);

  localparam int CNT_W = 8;
  localparam int REF_W = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_INTERVAL - 1);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PALL = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;

  typedef enum logic [3:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_REFRESH,
    S_REF_WAIT,
    S_ACTIVATE,
    S_RCD_WAIT,
    S_WRITE,
    S_WR_WAIT,
    S_READ,
    S_CAS_WAIT,
    S_PRECHARGE,
    S_RP_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic               ref_pending_q, ref_pending_d;
  logic               is_wr_q, is_wr_d;
  logic [24:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               oack_q, oack_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;

  logic               active;
  logic               ref_hit;
  logic               ref_due;
  logic [3:0]         cmd;
  logic [12:0]        addr_out;
  logic [1:0]         ba_out;
  logic [1:0]         dqm_out;
  logic               dq_oe;

  assign active  = (state_q != S_WAIT_INIT);
  assign ref_hit = active && (ref_cnt_q == REF_MAX);
  // A wrap in the current cycle counts as pending so IDLE reacts without a bubble.
  assign ref_due = ref_pending_q || ref_hit;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q       <= S_WAIT_INIT;
      wait_q        <= '0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      is_wr_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      oack_q        <= 1'b0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      is_wr_q       <= is_wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      oack_q        <= oack_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    ref_cnt_d     = ref_cnt_q;
    ref_pending_d = ref_pending_q;
    is_wr_d       = is_wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rvalid_d      = 1'b0;
    oack_d        = 1'b0;

    case (state_q)
      S_WAIT_INIT: begin
        if (iinit_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (ref_due) begin
          state_d = S_REFRESH;
        end else if (ireq_wr || ireq_rd) begin
          state_d = S_ACTIVATE;
          is_wr_d = ireq_wr;
          addr_d  = iaddr;
          wdata_d = iwdata;
        end
      end
      S_REFRESH: begin
        ref_pending_d = 1'b0;
        if (T_RC > 1) begin
          state_d = S_REF_WAIT;
          wait_d  = CNT_W'(T_RC - 2);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REF_WAIT: begin
        if (wait_q == '0) state_d = S_IDLE;
        else              wait_d  = wait_q - 1'b1;
      end
      S_ACTIVATE: begin
        if (T_RCD > 1) begin
          state_d = S_RCD_WAIT;
          wait_d  = CNT_W'(T_RCD - 2);
        end else begin
          state_d = is_wr_q ? S_WRITE : S_READ;
        end
      end
      S_RCD_WAIT: begin
        if (wait_q == '0) state_d = is_wr_q ? S_WRITE : S_READ;
        else              wait_d  = wait_q - 1'b1;
      end
      S_WRITE: begin
        state_d = S_WR_WAIT;
        wait_d  = CNT_W'(T_WR - 1);
      end
      S_WR_WAIT: begin
        if (wait_q == '0) state_d = S_PRECHARGE;
        else              wait_d  = wait_q - 1'b1;
      end
      S_READ: begin
        state_d = S_CAS_WAIT;
        wait_d  = CNT_W'(CAS_LAT - 1);
      end
      S_CAS_WAIT: begin
        if (wait_q == '0) begin
          // First burst word is on DQ now; the rest is cut off by PALL.
          rdata_d  = DRAM_DQ;
          rvalid_d = 1'b1;
          state_d  = S_PRECHARGE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_PRECHARGE: begin
        if (T_RP > 1) begin
          state_d = S_RP_WAIT;
          wait_d  = CNT_W'(T_RP - 2);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RP_WAIT: begin
        if (wait_q == '0) state_d = S_IDLE;
        else              wait_d  = wait_q - 1'b1;
      end
      default: state_d = S_WAIT_INIT;
    endcase

    if (active) begin
      if (ref_hit) begin
        ref_cnt_d     = '0;
        ref_pending_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 1'b1;
      end
    end

    if (active && !iinit_done) begin
      state_d  = S_WAIT_INIT;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
    end

    oack_d = ((state_d == S_RP_WAIT) && (wait_d == '0)) ||
             ((T_RP == 1) && (state_d == S_PRECHARGE) && (state_q != S_PRECHARGE));
  end

  always_comb begin
    cmd      = CMD_NOP;
    addr_out = '0;
    ba_out   = '0;
    dqm_out  = 2'b11;
    dq_oe    = 1'b0;
    case (state_q)
      S_REFRESH: cmd = CMD_REF;
      S_ACTIVATE: begin
        cmd      = CMD_ACT;
        ba_out   = addr_q[24:23];
        addr_out = addr_q[22:10];
        dqm_out  = 2'b00;
      end
      S_WRITE: begin
        cmd      = CMD_WR;
        ba_out   = addr_q[24:23];
        addr_out = {3'b000, addr_q[9:0]};
        dqm_out  = 2'b00;
        dq_oe    = 1'b1;
      end
      S_READ: begin
        cmd      = CMD_READ;
        ba_out   = addr_q[24:23];
        addr_out = {3'b000, addr_q[9:0]};
        dqm_out  = 2'b00;
      end
      S_PRECHARGE: begin
        cmd      = CMD_PALL;
        addr_out = 13'h0400;
        dqm_out  = 2'b00;
      end
      S_RCD_WAIT, S_WR_WAIT, S_CAS_WAIT, S_RP_WAIT: dqm_out = 2'b00;
      default: ;
    endcase
  end

  // Pins float while the init stage owns the bus.
  assign DRAM_CLK   = active ? ~iclk      : 1'bz;
  assign DRAM_CKE   = active ? 1'b1       : 1'bz;
  assign DRAM_ADDR  = active ? addr_out   : 13'bz;
  assign DRAM_BA    = active ? ba_out     : 2'bz;
  assign DRAM_CS_N  = active ? cmd[3]     : 1'bz;
  assign DRAM_RAS_N = active ? cmd[2]     : 1'bz;
  assign DRAM_CAS_N = active ? cmd[1]     : 1'bz;
  assign DRAM_WE_N  = active ? cmd[0]     : 1'bz;
  assign DRAM_UDQM  = active ? dqm_out[1] : 1'bz;
  assign DRAM_LDQM  = active ? dqm_out[0] : 1'bz;
  assign DRAM_DQ    = dq_oe  ? wdata_q    : 16'bz;

  assign oack         = oack_q;
  assign ordata       = rdata_q;
  assign ordata_valid = rvalid_q;
  assign obusy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_rw_ctrl.sv
// Directed bench for sdram_rw_ctrl with a tiny CL2 SDRAM data model.
module tb_sdram_rw_ctrl;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PALL = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;

  logic        clk = 1'b0;
  logic        rst, init_done, req_wr, req_rd;
  logic [24:0] addr;
  logic [15:0] wdata;
  logic        ack, rvalid, busy;
  logic [15:0] rdata;
  wire         dram_clk, cke, cs_n, ras_n, cas_n, we_n, udqm, ldqm;
  wire  [12:0] dram_addr;
  wire  [1:0]  ba;
  wire  [15:0] dq;
  wire  [3:0]  cmd;
  wire  [1:0]  dqm;

  logic        dq_oe = 1'b0;
  logic [15:0] dq_val = 16'h0;
  logic [15:0] mem_word = 16'h0;
  int          rd_age = 0;

  int checks = 0;
  int failures = 0;
  int idx = 0;

  assign dq  = dq_oe ? dq_val : 16'hzzzz;
  assign cmd = {cs_n, ras_n, cas_n, we_n};
  assign dqm = {udqm, ldqm};

  pullup   (cs_n);
  pullup   (dram_clk);
  pulldown (cke);
  pulldown (udqm);
  pulldown (ldqm);

  always #5 clk = ~clk;

  sdram_rw_ctrl dut (
    .iclk(clk), .ireset(rst), .iinit_done(init_done),
    .ireq_wr(req_wr), .ireq_rd(req_rd), .iaddr(addr), .iwdata(wdata),
    .oack(ack), .ordata(rdata), .ordata_valid(rvalid), .obusy(busy),
    .DRAM_CLK(dram_clk), .DRAM_CKE(cke), .DRAM_ADDR(dram_addr), .DRAM_BA(ba),
    .DRAM_CS_N(cs_n), .DRAM_RAS_N(ras_n), .DRAM_CAS_N(cas_n), .DRAM_WE_N(we_n),
    .DRAM_UDQM(udqm), .DRAM_LDQM(ldqm), .DRAM_DQ(dq)
  );

  // One-word memory: remembers the last write, answers READ at CL2 with a
  // decoy word one cycle early so a wrong capture point is visible.
  always @(negedge clk) begin
    if (cmd == CMD_WR) mem_word <= dq;
    if (cmd == CMD_RD)                    rd_age <= 1;
    else if (rd_age != 0 && rd_age < 4)   rd_age <= rd_age + 1;
    else                                  rd_age <= 0;
    dq_oe  <= (rd_age == 1) || (rd_age == 2);
    dq_val <= (rd_age == 2) ? mem_word : 16'h1234;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idx++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ref, second_ref;
    int ref3, wr_i, rd_i, ack1, ack2, acks, rv_i;
    logic [15:0] rd_val;
    logic [1:0]  ba_wr, ba_rd;
    int bad, idle_seen;

    rst = 1'b1; init_done = 1'b0; req_wr = 1'b0; req_rd = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_ack", ack, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cs_z", cs_n, 1);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) tick();
    check("init_cs_z", cs_n, 1);
    check("init_cke_z", cke, 0);
    check("init_clk_z", dram_clk, 1);
    check("init_dqm_z", dqm, 0);
    check("init_busy", busy, 1);

    init_done = 1'b1;
    tick();
    idx = 0;
    check("idle_busy", busy, 0);
    check("idle_cmd", cmd, CMD_NOP);
    check("idle_dqm", dqm, 2'b11);
    check("idle_cke", cke, 1);
    check("idle_clk", dram_clk, 0);

    // write: accepted in idx 0
    addr = {2'd0, 13'h0294, 10'h123};
    wdata = 16'hBEEF;
    req_wr = 1'b1;
    tick();
    wdata = 16'h0000;
    check("wr_act_cmd", cmd, CMD_ACT);
    check("wr_act_ba", ba, 0);
    check("wr_act_addr", dram_addr, 13'h0294);
    check("wr_act_dqm", dqm, 0);
    tick(); check("wr_rcd_nop", cmd, CMD_NOP);
    tick();
    check("wr_cmd", cmd, CMD_WR);
    check("wr_addr", dram_addr, 13'h0123);
    check("wr_dq", dq, 16'hBEEF);
    check("wr_dqm", dqm, 0);
    tick(); check("wr_nop1", cmd, CMD_NOP);
    tick(); check("wr_nop2", cmd, CMD_NOP); check("wr_noack", ack, 0);
    tick(); check("wr_pall", cmd, CMD_PALL); check("wr_pall_a10", dram_addr[10], 1);
    tick(); check("wr_rp_nop", cmd, CMD_NOP); check("wr_ack", ack, 1); check("wr_ack_idx", idx, 7);
    req_wr = 1'b0;
    tick(); check("wr_ack_pulse", ack, 0); check("wr_done_busy", busy, 0);

    // read of the same word: accepted in idx 8
    req_rd = 1'b1;
    tick(); check("rd_act_cmd", cmd, CMD_ACT); check("rd_act_addr", dram_addr, 13'h0294);
    tick(); check("rd_rcd_nop", cmd, CMD_NOP);
    tick();
    check("rd_cmd", cmd, CMD_RD);
    check("rd_addr", dram_addr, 13'h0123);
    check("rd_dqm", dqm, 0);
    tick(); check("rd_cas1_nop", cmd, CMD_NOP); check("rd_cas1_valid", rvalid, 0);
    tick(); check("rd_cas2_valid", rvalid, 0);
    tick();
    check("rd_pall", cmd, CMD_PALL);
    check("rd_valid", rvalid, 1);
    check("rd_data", rdata, 16'hBEEF);
    tick(); check("rd_ack", ack, 1); check("rd_valid_pulse", rvalid, 0); check("rd_ack_idx", idx, 15);
    req_rd = 1'b0;
    tick(); check("rd_hold", rdata, 16'hBEEF); check("rd_ack_pulse", ack, 0);

    // refresh cadence
    first_ref = -1;
    for (int n = 0; n < 500 && first_ref < 0; n++) begin
      tick();
      if (cmd == CMD_REF) first_ref = idx;
    end
    check("ref1_idx", first_ref, 390);
    check("ref1_dqm", dqm, 2'b11);
    tick(); check("refw1", cmd, CMD_NOP); check("refw1_busy", busy, 1);
    tick(); check("refw2", cmd, CMD_NOP);
    tick(); check("refw3", cmd, CMD_NOP); check("refw3_busy", busy, 1);
    tick(); check("ref_back_idle", busy, 0);
    second_ref = -1;
    for (int n = 0; n < 500 && second_ref < 0; n++) begin
      tick();
      if (cmd == CMD_REF) second_ref = idx;
    end
    check("ref2_idx", second_ref, 780);

    // both requests raised as the third refresh falls due
    while (idx < 1169) tick();
    addr = {2'd3, 13'h1ABC, 10'h2F5};
    wdata = 16'h5A3C;
    req_wr = 1'b1; req_rd = 1'b1;
    ref3 = -1; wr_i = -1; rd_i = -1; ack1 = -1; ack2 = -1; acks = 0; rv_i = -1;
    rd_val = '0; ba_wr = '0; ba_rd = '0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (cmd == CMD_REF && ref3 < 0) ref3 = idx;
      if (cmd == CMD_WR && wr_i < 0) begin wr_i = idx; ba_wr = ba; end
      if (cmd == CMD_RD && rd_i < 0) begin rd_i = idx; ba_rd = ba; end
      if (rvalid) begin rv_i = idx; rd_val = rdata; end
      if (ack) begin
        acks++;
        if (ack1 < 0) begin ack1 = idx; req_wr = 1'b0; end
        else begin ack2 = idx; req_rd = 1'b0; end
      end
    end
    check("race_ref_idx", ref3, 1170);
    check("race_wr_idx", wr_i, 1177);
    check("race_wr_ba", ba_wr, 3);
    check("race_ack1_idx", ack1, 1181);
    check("race_rd_idx", rd_i, 1185);
    check("race_rd_ba", ba_rd, 3);
    check("race_rv_idx", rv_i, 1188);
    check("race_rd_data", rd_val, 16'h5A3C);
    check("race_ack2_idx", ack2, 1189);
    check("race_acks", acks, 2);

    // reset in CAS_WAIT
    addr = {2'd1, 13'h0042, 10'h011};
    req_rd = 1'b1;
    repeat (4) tick();
    check("cas_busy", busy, 1);
    check("cas_nop", cmd, CMD_NOP);
    rst = 1'b1;
    #1;
    check("rst_mid_cs_z", cs_n, 1);
    check("rst_mid_cke_z", cke, 0);
    req_rd = 1'b0;
    bad = 0;
    repeat (3) begin
      tick();
      if (ack || rvalid) bad++;
    end
    check("rst_mid_no_ack", bad, 0);
    check("rst_mid_rdata", rdata, 0);
    rst = 1'b0;
    idle_seen = 0;
    for (int n = 0; n < 2 && idle_seen == 0; n++) begin
      tick();
      if (!busy) idle_seen = 1;
    end
    check("rst_release_idle", idle_seen, 1);

    // init_done drop mid-access
    req_wr = 1'b1;
    wdata = 16'h7777;
    tick(); check("drop_act", cmd, CMD_ACT);
    init_done = 1'b0;
    tick(); check("drop_cs_z", cs_n, 1); check("drop_busy", busy, 1);
    req_wr = 1'b0;
    bad = 0;
    repeat (10) begin
      tick();
      if (ack) bad++;
    end
    check("drop_no_ack", bad, 0);
    init_done = 1'b1;
    tick(); check("drop_reidle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
